// File: rtl/riscv_pkg.sv
// Shared RISC-V core types: LSU operation encoding and classification helpers.
package riscv_pkg;

  typedef enum logic [3:0] {
    LSU_NONE, LB, LH, LW, LD, LBU, LHU, LWU, SB, SH, SW, SD
  } lsu_op_t;

  function automatic logic lsu_is_load(lsu_op_t op);
    return op inside {LB, LH, LW, LD, LBU, LHU, LWU};
  endfunction

  function automatic logic lsu_is_store(lsu_op_t op);
    return op inside {SB, SH, SW, SD};
  endfunction

  // log2 of the access size in bytes
  function automatic logic [1:0] lsu_size(lsu_op_t op);
    case (op)
      LH, LHU, SH:     return 2'd1;
      LW, LWU, SW:     return 2'd2;
      LD, SD:          return 2'd3;
      default:         return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the LSU: store byte enables/data replication, misalignment, load extract/extend.
// Latency: purely combinational, zero cycles.
// Backpressure: none; caller decides when inputs are meaningful.
module lsu_align
  import riscv_pkg::*;
(
  input  lsu_op_t     req_op,
  input  logic [2:0]  req_off,
  input  logic [63:0] store_data,
  output logic [7:0]  be,
  output logic [63:0] wdata,
  output logic        misaligned,
  input  lsu_op_t     rsp_op,
  input  logic [2:0]  rsp_off,
  input  logic [63:0] rdata,
  output logic [63:0] load_data
);

  logic [63:0] shifted;

  always_comb begin
    be         = 8'hFF;
    wdata      = store_data;
    misaligned = 1'b0;
    case (lsu_size(req_op))
      2'd0: begin
        be    = 8'h01 << req_off;
        wdata = {8{store_data[7:0]}};
      end
      2'd1: begin
        be         = 8'h03 << req_off;
        wdata      = {4{store_data[15:0]}};
        misaligned = req_off[0];
      end
      2'd2: begin
        be         = 8'h0F << req_off;
        wdata      = {2{store_data[31:0]}};
        misaligned = |req_off[1:0];
      end
      default: begin
        be         = 8'hFF;
        wdata      = store_data;
        misaligned = |req_off;
      end
    endcase
  end

  always_comb begin
    shifted = rdata >> {rsp_off, 3'b000};
    case (rsp_op)
      LB:      load_data = {{56{shifted[7]}},  shifted[7:0]};
      LH:      load_data = {{48{shifted[15]}}, shifted[15:0]};
      LW:      load_data = {{32{shifted[31]}}, shifted[31:0]};
      LBU:     load_data = {56'b0, shifted[7:0]};
      LHU:     load_data = {48'b0, shifted[15:0]};
      LWU:     load_data = {32'b0, shifted[31:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit: one data-memory access per EX/MEM op, result and exceptions to MEM/WB.
// Latency: 3 cycles accept-to-RESP minimum (grant first REQ cycle, rvalid next); misaligned ops 1 cycle.
// Backpressure: busy_o stalls the front end while in IDLE-accept/REQ/WAIT; dmem_req_o held until dmem_gnt_i.
module lsu_mem_stage
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] alu_result_i,
  input  logic [63:0] store_data_i,
  input  lsu_op_t     lsu_op_i,
  input  logic        mem_write_i,
  input  logic        mem_to_reg_i,
  output logic        busy_o,
  output logic        dmem_req_o,
  input  logic        dmem_gnt_i,
  output logic        dmem_we_o,
  output logic [63:0] dmem_addr_o,
  output logic [7:0]  dmem_be_o,
  output logic [63:0] dmem_wdata_o,
  input  logic        dmem_rvalid_i,
  input  logic [63:0] dmem_rdata_i,
  input  logic        dmem_err_i,
  output logic        load_valid_o,
  output logic [63:0] load_data_o,
  output logic        exc_misaligned_o,
  output logic        exc_fault_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t      state_q, state_d;
  lsu_op_t     op_q;
  logic [2:0]  off_q;
  logic        m2r_q, mis_q, fault_q;
  logic [31:0] cnt_q;
  logic [7:0]  be_c;
  logic [63:0] wdata_c, load_ext;
  logic        mis_c, accept, timeout, busy_c;

  lsu_align u_align (
    .req_op     (lsu_op_i),
    .req_off    (alu_result_i[2:0]),
    .store_data (store_data_i),
    .be         (be_c),
    .wdata      (wdata_c),
    .misaligned (mis_c),
    .rsp_op     (op_q),
    .rsp_off    (off_q),
    .rdata      (dmem_rdata_i),
    .load_data  (load_ext)
  );

  assign accept = (state_q == S_IDLE) && (lsu_op_i != LSU_NONE);
  // RESP lands exactly TIMEOUT_CYCLES cycles after the grant cycle
  assign timeout = (TIMEOUT_CYCLES != 0) && ((cnt_q + 32'd2) >= TIMEOUT_CYCLES);

  always_comb begin
    state_d    = state_q;
    busy_c     = 1'b0;
    dmem_req_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy_c = accept;
        if (accept) state_d = mis_c ? S_RESP : S_REQ;
      end
      S_REQ: begin
        busy_c     = 1'b1;
        dmem_req_o = 1'b1;
        if (dmem_gnt_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        busy_c = 1'b1;
        if (dmem_rvalid_i || timeout) state_d = S_RESP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stalled EX/MEM keeps presenting the op during reset; keep the stall quiet there.
  assign busy_o = rst_n & busy_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      op_q         <= LSU_NONE;
      off_q        <= '0;
      m2r_q        <= 1'b0;
      mis_q        <= 1'b0;
      fault_q      <= 1'b0;
      cnt_q        <= '0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= '0;
      dmem_be_o    <= '0;
      dmem_wdata_o <= '0;
      load_data_o  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: if (accept) begin
          op_q         <= lsu_op_i;
          off_q        <= alu_result_i[2:0];
          m2r_q        <= mem_to_reg_i;
          mis_q        <= mis_c;
          fault_q      <= 1'b0;
          dmem_we_o    <= lsu_is_store(lsu_op_i);
          dmem_addr_o  <= {alu_result_i[63:3], 3'b000};
          dmem_be_o    <= be_c;
          dmem_wdata_o <= wdata_c;
        end
        S_REQ: if (dmem_gnt_i) cnt_q <= '0;
        S_WAIT: begin
          cnt_q <= cnt_q + 32'd1;
          if (dmem_rvalid_i) begin
            fault_q <= dmem_err_i;
            if (lsu_is_load(op_q) && !dmem_err_i) load_data_o <= load_ext;
          end else if (timeout) begin
            fault_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign load_valid_o     = (state_q == S_RESP) && lsu_is_load(op_q) && m2r_q && !mis_q && !fault_q;
  assign exc_misaligned_o = (state_q == S_RESP) && mis_q;
  assign exc_fault_o      = (state_q == S_RESP) && fault_q;

  a_no_rvalid_with_gnt: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == S_REQ && dmem_gnt_i) |-> !dmem_rvalid_i);

  a_store_flag_matches_op: assert property (@(posedge clk) disable iff (!rst_n)
    accept |-> (mem_write_i == lsu_is_store(lsu_op_i)));

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
MEM-stage load/store unit. Consumes the EX/MEM register outputs (address, store data, lsu_op) and drives the data-memory request/response port. It aligns store data with byte enables and sign/zero-extends load data. It stalls the front of the pipeline until the access completes and hands the load result and exceptions to the MEM/WB register.

Parameters:
TIMEOUT_CYCLES, 255, max cycles waiting for dmem_rvalid_i before access fault; 0 disables timeout

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
alu_result_i  in  64  effective byte address from EX/MEM
store_data_i  in  64  store data from EX/MEM
lsu_op_i  in  lsu_op_t  memory op from EX/MEM; LSU_NONE = no access
mem_write_i  in  1  store flag from EX/MEM
mem_to_reg_i  in  1  load-writeback flag from EX/MEM
busy_o  out  1  stall request to IF/ID/EX and EX/MEM
dmem_req_o  out  1  memory request valid
dmem_gnt_i  in  1  request accepted
dmem_we_o  out  1  1 = write
dmem_addr_o  out  64  doubleword-aligned address (bits [2:0]=0)
dmem_be_o  out  8  byte enables
dmem_wdata_o  out  64  lane-replicated write data
dmem_rvalid_i  in  1  response valid
dmem_rdata_i  in  64  response data
dmem_err_i  in  1  response error, qualified by rvalid
load_valid_o  out  1  load_data_o valid this cycle
load_data_o  out  64  extended load result
exc_misaligned_o  out  1  one-cycle misaligned exception
exc_fault_o  out  1  one-cycle access-fault exception

Behaviour:
- Clock and reset: clk, rst_n; reset asynchronous, active-low.
- Reset values: all outputs 0; FSM in IDLE; timeout counter 0.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE, lsu_op_i==LSU_NONE: busy_o=0, stay in IDLE.
- IDLE, any other op:
  - busy_o=1 combinationally.
  - Latch address[2:0], op, be, wdata, aligned address.
  - Misaligned (LH/LHU/SH addr[0]; LW/LWU/SW addr[1:0]!=0; LD/SD addr[2:0]!=0): go to RESP with misaligned flag; no memory request.
  - Otherwise go to REQ.
- REQ:
  - dmem_req_o=1 with stable we/addr/be/wdata until dmem_gnt_i.
  - On gnt go to WAIT; clear timeout counter.
  - busy_o=1.
- WAIT:
  - busy_o=1; counter increments each cycle.
  - dmem_rvalid_i: capture extended data; go to RESP with fault flag = dmem_err_i.
  - Counter reaching TIMEOUT_CYCLES with no rvalid: go to RESP with fault flag.
  - rvalid in the same cycle as gnt is illegal; ignored; assertion fires.
- RESP:
  - busy_o=0; EX/MEM advances at this edge.
  - load_valid_o=1 only for a load with mem_to_reg latched and no exception.
  - exc_misaligned_o / exc_fault_o pulse here.
  - Next state IDLE unconditionally; the stale op still on the inputs this cycle is never re-accepted.
- Minimum latency, accept to RESP: 3 cycles with gnt in the first REQ cycle and rvalid the cycle after.
- Store byte enables:
  - SB: 0x01<<a; SH: 0x03<<a; SW: 0x0F<<a; SD: 0xFF (a = addr[2:0]).
- Store write data:
  - SB: data[7:0] ×8; SH: data[15:0] ×4; SW: data[31:0] ×2; SD: as is.
- Loads:
  - Shifted = rdata >> (a*8).
  - LB/LH/LW sign-extend from bit 7/15/31; LBU/LHU/LWU zero-extend; LD pass-through.
  - Stores complete on rvalid; store rdata is ignored.
- Store classification: lsu_op_i is authoritative. mem_write_i must equal "op is store"; assertion on mismatch.
- Reset mid-transaction: immediate return to IDLE with req dropped. The memory side is reset on the same rst_n.
- load_data_o holds its last value outside RESP.

Decomposition:
- riscv_pkg: lsu_op_t (LSU_NONE, LB, LH, LW, LD, LBU, LHU, LWU, SB, SH, SW, SD) and helper functions lsu_is_load, lsu_is_store, lsu_size.
- Local FSM state enum stays in the module.
- Sub-module lsu_align: combinational store be/wdata generation, load extract/extend, misalignment check.
- FSM and timeout counter stay in lsu_mem_stage.

Test Plan:
1. SW, addr 0x1004, data 0xDEADBEEF; gnt in cycle 1, rvalid in cycle 2 → dmem_addr 0x1000, be 0xF0, wdata 0xDEADBEEF_DEADBEEF, we=1; busy 3 cycles; no load_valid.
2. LB, addr 0x2003, rdata 0x00000000_80000000 → load_data 0xFFFFFFFF_FFFFFF80. LBU on the same address → 0x00000000_00000080.
3. LW, addr 0x3002 → no dmem_req; RESP exc_misaligned_o=1 for one cycle; busy_o high exactly 1 cycle.
4. LD with gnt delayed 4 cycles → req/addr/be stable throughout; busy held; no double request.
5. LD, rvalid never returns, TIMEOUT_CYCLES=8 → exc_fault_o pulses 8 cycles after gnt. Separately, rvalid with err=1 → exc_fault_o, no load_valid.
6. rst_n low while in WAIT → req, busy, and all outputs 0 immediately. Back-to-back LD then SD → the second op is accepted the cycle after RESP; no duplicate access.
